// File: rtl/mu0_sequencer_if.sv
// Bus bundle between the MU0 sequencer and its environment (RAM, decoder, run/debug control).
// The single-step port pair exists only when MU0_SINGLE_STEP_EN is defined.
interface mu0_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  // Control inputs are level signals sampled on each rising clk edge; there is
  // no valid/ready pair: ramData is consumed only in FETCH and extra only in EXEC1.
  logic                  run;
  logic [DATA_WIDTH-1:0] ramData;
  logic                  extra;
  logic                  fetch;
  logic                  exec1;
  logic                  exec2;
  logic [3:0]            mux2r;
  logic [DATA_WIDTH-5:0] operand;
  logic                  halted;
  logic [CNT_WIDTH-1:0]  instrCount;
  logic [2:0]            state_dbg;
`ifdef MU0_SINGLE_STEP_EN
  logic                  stepMode;
  logic                  step;
`endif

  modport master (
    output run, ramData, extra,
`ifdef MU0_SINGLE_STEP_EN
    output stepMode, step,
`endif
    input  fetch, exec1, exec2, mux2r, operand, halted, instrCount, state_dbg
  );

  modport slave (
    input  run, ramData, extra,
`ifdef MU0_SINGLE_STEP_EN
    input  stepMode, step,
`endif
    output fetch, exec1, exec2, mux2r, operand, halted, instrCount, state_dbg
  );
endinterface

// File: rtl/mu0_sequencer.sv
// MU0 control sequencer and instruction register: one-hot phase strobes, opcode/operand
// presentation and saturating retire counter. Optional single-step: MU0_SINGLE_STEP_EN.
module mu0_sequencer #(
  parameter int          DATA_WIDTH = 16,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [3:0]  STP_OPCODE = 4'd7
) (
  input  logic            clk,
  input  logic            reset,
  mu0_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  fetch_q, exec1_q, exec2_q, halted_q;
  logic                  retire;
  logic [3:0]            op_in;

  assign op_in = bus.ramData[DATA_WIDTH-1 -: 4];

`ifdef MU0_SINGLE_STEP_EN
  logic step_prev_q;
  logic step_rise;
  assign step_rise = bus.step & ~step_prev_q;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d = bus.ramData;
        if (op_in == STP_OPCODE) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC1;
        end
      end
      // Only a definite 1 on extra selects EXEC2; anything else retires the instruction.
      S_EXEC1: begin
        if (bus.extra == 1'b1) begin
          state_d = S_EXEC2;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC2: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
`ifdef MU0_SINGLE_STEP_EN
      S_PAUSE: if (!bus.stepMode || step_rise) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef MU0_SINGLE_STEP_EN
    // Retirement parks in PAUSE when stepping; STP still goes straight to HALT.
    if (retire && bus.stepMode && (state_d == S_FETCH)) state_d = S_PAUSE;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      cnt_q    <= '0;
      fetch_q  <= 1'b0;
      exec1_q  <= 1'b0;
      exec2_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef MU0_SINGLE_STEP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      fetch_q  <= (state_d == S_FETCH);
      exec1_q  <= (state_d == S_EXEC1);
      exec2_q  <= (state_d == S_EXEC2);
      halted_q <= (state_d == S_HALT);
`ifdef MU0_SINGLE_STEP_EN
      step_prev_q <= bus.step;
`endif
    end
  end

  // FETCH shows the word being fetched so the decoder can act in the same cycle.
  assign bus.mux2r      = (state_q == S_FETCH) ? op_in : ir_q[DATA_WIDTH-1 -: 4];
  assign bus.operand    = (state_q == S_FETCH) ? bus.ramData[DATA_WIDTH-5:0]
                                               : ir_q[DATA_WIDTH-5:0];
  assign bus.fetch      = fetch_q;
  assign bus.exec1      = exec1_q;
  assign bus.exec2      = exec2_q;
  assign bus.halted     = halted_q;
  assign bus.instrCount = cnt_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed bench for mu0_sequencer; small counter width so saturation is reachable.
module tb_mu0_sequencer;
  localparam int DW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mu0_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  mu0_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .STP_OPCODE(4'd7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, bus.fetch, bus.exec1, bus.exec2}, {29'd0, exp});
  endtask

  initial begin
    reset       = 1'b1;
    bus.run     = 1'b0;
    bus.ramData = '0;
    bus.extra   = 1'b0;
`ifdef MU0_SINGLE_STEP_EN
    bus.stepMode = 1'b0;
    bus.step     = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;

    // Reset state and idling with run low
    chk_strobes("rst_strobes", 3'b000);
    chk("rst_cnt", bus.instrCount, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_mux2r", bus.mux2r, 0);
    chk("rst_operand", bus.operand, 0);
    chk("rst_state", bus.state_dbg, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_strobes("idle_strobes", 3'b000);
    end
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    chk_strobes("start_fetch", 3'b100);

    // JMP 0x123, no extra cycle
    bus.ramData = 16'h4123;
    settle();
    chk("jmp_mux2r_pass", bus.mux2r, 4'h4);
    chk("jmp_operand_pass", bus.operand, 12'h123);
    tick();
    bus.ramData = 16'h0000;
    settle();
    chk_strobes("jmp_exec1", 3'b010);
    chk("jmp_mux2r_ir", bus.mux2r, 4'h4);
    chk("jmp_operand_ir", bus.operand, 12'h123);
    tick();
    chk_strobes("jmp_refetch", 3'b100);
    chk("jmp_cnt", bus.instrCount, 1);

    // ADD with EXEC2, ramData changes after FETCH
    bus.ramData = 16'h2010;
    settle();
    chk("add_mux2r_pass", bus.mux2r, 4'h2);
    tick();
    bus.ramData = 16'hFFFF;
    bus.extra   = 1'b1;
    settle();
    chk_strobes("add_exec1", 3'b010);
    chk("add_mux2r_exec1", bus.mux2r, 4'h2);
    chk("add_operand_exec1", bus.operand, 12'h010);
    tick();
    chk_strobes("add_exec2", 3'b001);
    chk("add_mux2r_exec2", bus.mux2r, 4'h2);
    chk("add_cnt_exec2", bus.instrCount, 1);
    tick();
    bus.extra = 1'b0;
    chk_strobes("add_refetch", 3'b100);
    chk("add_cnt", bus.instrCount, 2);

    // Reset asserted during EXEC2
    bus.ramData = 16'h1005;
    bus.extra   = 1'b1;
    tick();
    tick();
    chk_strobes("mid_exec2", 3'b001);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    bus.extra = 1'b0;
    chk_strobes("mid_rst_strobes", 3'b000);
    chk("mid_rst_cnt", bus.instrCount, 0);
    chk("mid_rst_mux2r", bus.mux2r, 0);
    chk("mid_rst_state", bus.state_dbg, 0);
    tick();
    chk_strobes("mid_rst_stays_idle", 3'b000);

    // STP halts; run is then ignored until reset
    bus.run = 1'b1;
    tick();
    bus.run     = 1'b0;
    bus.ramData = 16'h7000;
    settle();
    chk("stp_mux2r_pass", bus.mux2r, 4'h7);
    tick();
    bus.ramData = 16'h4123;
    settle();
    chk("stp_halted", bus.halted, 1);
    chk_strobes("stp_strobes", 3'b000);
    chk("stp_mux2r_ir", bus.mux2r, 4'h7);
    chk("stp_cnt", bus.instrCount, 1);
    for (int i = 0; i < 10; i++) begin
      bus.run = ~bus.run;
      tick();
      chk("halt_hold", {bus.halted, bus.fetch, bus.exec1, bus.exec2}, 4'b1000);
    end
    bus.run = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_rst_halted", bus.halted, 0);
    chk("halt_rst_state", bus.state_dbg, 0);
    chk("halt_rst_mux2r", bus.mux2r, 0);

    // Counter saturation with short instructions (CW=4 -> max 15)
    bus.run = 1'b1;
    tick();
    bus.run     = 1'b0;
    bus.ramData = 16'h0005;
    bus.extra   = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      tick();
      chk("sat_cnt", bus.instrCount, (i > 15) ? 15 : i);
    end
    chk_strobes("sat_fetch", 3'b100);

`ifdef MU0_SINGLE_STEP_EN
    // Single-step: LDA stream, each retirement parks in PAUSE
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.stepMode = 1'b1;
    bus.extra    = 1'b1;
    bus.ramData  = 16'h0005;
    bus.run      = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    tick();
    tick();
    chk_strobes("ss_pause1", 3'b000);
    chk("ss_cnt1", bus.instrCount, 1);
    chk("ss_state_pause", bus.state_dbg, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ss_stay_pause", bus.state_dbg, 5);
    end
    bus.step = 1'b1;
    tick();
    chk_strobes("ss_step_fetch", 3'b100);
    tick();
    tick();
    tick();
    chk("ss_cnt2", bus.instrCount, 2);
    chk("ss_held_step_pause", bus.state_dbg, 5);
    tick();
    chk("ss_held_step_still", bus.state_dbg, 5);
    bus.step     = 1'b0;
    bus.stepMode = 1'b0;
    tick();
    chk_strobes("ss_mode_off_fetch", 3'b100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mu0_sequencer.md
Name: mu0_sequencer

Overview:
- Control sequencer and instruction register for the MU0 CPU; sits directly upstream of the opcode decoder.
- Generates the one-hot phase strobes fetch/exec1/exec2 and presents the 4-bit opcode (mux2r) and 12-bit operand.
- Consumes the decoder's `extra` output to decide whether an EXEC2 cycle is needed.
- Halts on STP and keeps a retired-instruction count for debug.

Parameters:
- DATA_WIDTH, 16, instruction word width; opcode = top 4 bits, operand = remaining bits.
- CNT_WIDTH, 16, width of retired-instruction counter.
- STP_OPCODE, 7, opcode value that halts the sequencer.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  start request; leaves IDLE when high.
- ramData  input  DATA_WIDTH  instruction word read from RAM at current address.
- extra  input  1  from decoder: current opcode needs an EXEC2 cycle.
- fetch  output  1  FETCH phase strobe.
- exec1  output  1  EXEC1 phase strobe.
- exec2  output  1  EXEC2 phase strobe.
- mux2r  output  4  opcode to decoder.
- operand  output  DATA_WIDTH-4  address/immediate field of current instruction.
- halted  output  1  high while in HALT.
- instrCount  output  CNT_WIDTH  retired-instruction count, saturating.

Behaviour:
- States: IDLE, FETCH, EXEC1, EXEC2, HALT (plus PAUSE with the optional feature).
- Strobes are registered and one-hot: fetch=1 only in FETCH, exec1 only in EXEC1, exec2 only in EXEC2. All three are 0 in IDLE, HALT and PAUSE.
- Reset (synchronous, any state, including mid-instruction):
  - State goes to IDLE; IR=0; instrCount=0; halted=0; strobes 0.
  - mux2r=0 and operand=0.
- IDLE: go to FETCH on the next edge when run=1, otherwise stay.
- FETCH:
  - mux2r = ramData[DATA_WIDTH-1 -: 4] (combinational pass-through), so the decoder sees the new opcode in the same cycle.
  - operand = ramData low bits, also pass-through.
  - IR loads ramData at the end of the cycle.
  - If the pass-through opcode == STP_OPCODE, the next state is HALT, IR still loads, and instrCount increments once (STP retires).
  - Otherwise the next state is EXEC1.
- EXEC1 and EXEC2: mux2r and operand are driven from IR.
- EXEC1:
  - `extra` is sampled only in this state.
  - extra=1 → EXEC2.
  - extra=0 → FETCH, and instrCount increments.
- EXEC2: go to FETCH unconditionally; instrCount increments.
- HALT:
  - halted=1; mux2r/operand driven from IR.
  - run is ignored. Only reset exits.
- instrCount saturates at all-ones and never wraps.
- Outside FETCH, the ramData value has no effect.
- `extra` outside EXEC1 is ignored, and X on it there must not propagate into state.
- Latency:
  - Non-extra instruction: 2 cycles (FETCH, EXEC1).
  - Extra instruction (LDA/ADD/SUB): 3 cycles.
  - STP: 1 cycle, then HALT.
- run deasserted after leaving IDLE has no effect (run is a start request only).

Optional Feature:
- Macro: MU0_SINGLE_STEP_EN.
- When defined:
  - Adds input ports stepMode (1) and step (1), plus state PAUSE.
  - With stepMode=1, every instruction retirement (increment point) goes to PAUSE instead of FETCH.
  - PAUSE: all strobes 0; mux2r/operand driven from IR.
  - PAUSE → FETCH on a cycle where step=1. A held step advances only one instruction; a 0→1 transition is required, and the previous step value is registered for edge detection.
  - stepMode=0 while in PAUSE → FETCH on the next edge.
  - STP still goes to HALT, never PAUSE.
  - Reset clears PAUSE and the step-edge register.
- When undefined: the ports and PAUSE state do not exist; the sequencer runs continuously.

Test Plan:
- Reset, run=0 for 5 cycles → strobes all 0, instrCount=0. Then run=1 for 1 cycle → fetch=1 on the next cycle.
- ramData=0x4123 (JMP) in FETCH with extra=0 → mux2r=4 and operand=0x123 in the same cycle; EXEC1 next; then FETCH; instrCount=1.
- ramData=0x2010 (ADD), extra=1 in EXEC1 → sequence FETCH, EXEC1, EXEC2, FETCH; mux2r=2 held through EXEC1/EXEC2 even if ramData changes to 0xFFFF; instrCount +1.
- ramData=0x7000 in FETCH → next cycle halted=1, strobes 0, mux2r=7. run toggled 10 cycles → remains halted. Reset → IDLE, halted=0.
- Reset asserted during EXEC2 → next cycle IDLE, instrCount=0, mux2r=0.
- With MU0_SINGLE_STEP_EN, stepMode=1, stream of 0x0005 (LDA):
  - First instruction retires into PAUSE, then stays paused.
  - step held high 4 cycles → exactly one more instruction executes (instrCount=2).
  - Preload instrCount near saturation: after 0xFFFF, stays at 0xFFFF.
